pwm_demod: RTL

Receive-side counterpart of the audio PWM DAC. It measures the high time of a PWM waveform over fixed windows of CYCLES_PER_WINDOW clocks and returns the duty code, with a one-cycle valid strobe per window. It aligns its window to the rising edge that the DAC emits at each window start. It sits on the loopback/test path: the DAC's PWM output feeds it so that a bench or an on-board checker can compare recovered codes against the generated samples.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_demod_synchronizer.sv | 42 ++++
 rtl/pwm_demod.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM DAC and the PWM demodulator.
//   demod_state_t         : demodulator alignment state (HUNT / LOCKED)
//   PWM_CYCLES_PER_WINDOW : default clocks per PWM window, common to DAC and demod
package pwm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } demod_state_t;

  localparam int PWM_CYCLES_PER_WINDOW = 1024;

endpackage : pwm_pkg

// File: rtl/pwm_demod_synchronizer.sv
// pwm_demod_synchronizer: STAGES-deep single-bit flop chain used to bring the
// PWM pin into the clk domain (STAGES = 2 for asynchronous sources, 1 for a
// plain capture flop when the source already runs on clk).
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : raw input
//   q     : input delayed by STAGES clocks
module pwm_demod_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;
  logic [STAGES-1:0] stage_next;

  // Each stage takes the previous one; stage 0 takes the pin.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_next[gi] = d;
      end else begin : g_rest
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule : pwm_demod_synchronizer

// File: rtl/pwm_demod.sv
// pwm_demod: recovers the duty code of a PWM waveform by counting its high
// clocks over windows of CYCLES_PER_WINDOW clocks. The window is aligned to
// the rising edge the DAC emits at every window start.
//
// Build option: define PWM_DEMOD_SYNC_EN to pass pwm through a 2-flop
// synchronizer (asynchronous/off-chip source). Without it pwm is captured by a
// single flop (same-clock loopback), one clock less latency.
//
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   pwm        : PWM input, may be asynchronous to clk
//   code       : last recovered duty code, held between windows
//   code_valid : one-cycle pulse when code is updated
//   locked     : high once a window start has been found (cleared by reset)
//   relock     : one-cycle pulse when a misaligned rising edge realigns the window
module pwm_demod
  import pwm_pkg::*;
#(
  parameter  int CYCLES_PER_WINDOW = PWM_CYCLES_PER_WINDOW,
  localparam int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  code_valid,
  output logic                  locked,
  output logic                  relock
);

  localparam int CNT_WIDTH = CODE_WIDTH + 1;
  localparam logic [CODE_WIDTH-1:0] POS_LAST  = CODE_WIDTH'(CYCLES_PER_WINDOW - 1);
  localparam logic [CODE_WIDTH-1:0] POS_ONE   = CODE_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CODE_MAX  = CNT_WIDTH'((1 << CODE_WIDTH) - 1);

`ifdef PWM_DEMOD_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif

  logic pwm_s;
  logic pwm_q_reg;
  logic rise;

  demod_state_t          state_reg;
  logic [CODE_WIDTH-1:0] pos_reg;     // window position of the current cycle
  logic [CNT_WIDTH-1:0]  hi_cnt_reg;  // high clocks seen before the current cycle
  logic [CNT_WIDTH-1:0]  hi_cnt_next; // count including the current cycle
  logic [CODE_WIDTH-1:0] code_next;   // saturated final count
  logic [CODE_WIDTH-1:0] code_reg;
  logic                  code_valid_reg;
  logic                  locked_reg;
  logic                  relock_reg;

  pwm_demod_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pwm),
    .q     (pwm_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q_reg <= 1'b0;
    end else begin
      pwm_q_reg <= pwm_s;
    end
  end

  assign rise        = pwm_s & ~pwm_q_reg;
  assign hi_cnt_next = hi_cnt_reg + {{CODE_WIDTH{1'b0}}, pwm_s};
  // Only an all-high window with a power-of-two length can exceed the code range.
  assign code_next   = (hi_cnt_next > CODE_MAX) ? CODE_MAX[CODE_WIDTH-1:0]
                                                : hi_cnt_next[CODE_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= HUNT;
      pos_reg        <= '0;
      hi_cnt_reg     <= '0;
      code_reg       <= '0;
      code_valid_reg <= 1'b0;
      locked_reg     <= 1'b0;
      relock_reg     <= 1'b0;
    end else begin
      code_valid_reg <= 1'b0;
      relock_reg     <= 1'b0;
      case (state_reg)
        HUNT: begin
          // The rise cycle is position 0 and already counts as one high clock,
          // so the registers step straight to position 1.
          if (rise) begin
            state_reg  <= LOCKED;
            locked_reg <= 1'b1;
            pos_reg    <= POS_ONE;
            hi_cnt_reg <= CNT_ONE;
          end
        end
        LOCKED: begin
          if (rise && (pos_reg != '0)) begin
            // Edge where none belongs: drop the partial window and restart
            // with this cycle as position 0.
            relock_reg <= 1'b1;
            pos_reg    <= POS_ONE;
            hi_cnt_reg <= CNT_ONE;
          end else if (pos_reg == POS_LAST) begin
            code_reg       <= code_next;
            code_valid_reg <= 1'b1;
            pos_reg        <= '0;
            hi_cnt_reg     <= '0;
          end else begin
            pos_reg    <= pos_reg + POS_ONE;
            hi_cnt_reg <= hi_cnt_next;
          end
        end
        default: begin
          state_reg <= HUNT;
        end
      endcase
    end
  end

  assign code       = code_reg;
  assign code_valid = code_valid_reg;
  assign locked     = locked_reg;
  assign relock     = relock_reg;

endmodule : pwm_demod
